// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// start/stop levels of the EX request handshake.
package div_iter_pkg;

    typedef enum logic [1:0] {
        DivIdle = 2'b00,
        DivBusy = 2'b01,
        DivDone = 2'b10
    } div_state_e;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    localparam int DIV_WIDTH_MIN = 8;
    localparam int DIV_WIDTH_MAX = 64;

endpackage

// File: rtl/div_abs_cmp.sv
// Operand magnitude extraction for the divider. Produces |a| and |b|, the
// operand sign flags used later by the sign fix-up, the early-out compare
// |a| < |b| and the zero-divisor detect.
module div_abs_cmp
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             signed_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] mag_b,
    output logic             neg_a,
    output logic             neg_b,
    output logic             a_lt_b,
    output logic             b_zero
);

    // Two's-complement magnitudes; in unsigned mode the operands pass through.
    always_comb begin
        neg_a  = signed_div & op_a[WIDTH-1];
        neg_b  = signed_div & op_b[WIDTH-1];
        mag_a  = op_a;
        mag_b  = op_b;
        if (neg_a) begin
            mag_a = ~op_a + WIDTH'(1);
        end else begin
            mag_a = op_a;
        end
        if (neg_b) begin
            mag_b = ~op_b + WIDTH'(1);
        end else begin
            mag_b = op_b;
        end
        a_lt_b = (mag_a < mag_b);
        b_zero = (op_b == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/div_iter.sv
// Parametrised multi-cycle integer divider for the EX stage. Restoring
// division on operand magnitudes, one quotient bit per cycle, with sign
// fix-up on the last step. Zero divisor and (optionally) |a| < |b| finish on
// the accepting edge. Keeps the EX start/annul/ready handshake.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               divzero_o
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] dvd_r;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] rem_r;      // partial remainder
    logic [WIDTH-1:0] dsr_r;      // |divisor|
    logic             neg_quo_r;
    logic             neg_rem_r;

    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic             neg_a_s;
    logic             neg_b_s;
    logic             a_lt_b_s;
    logic             b_zero_s;

    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   diff_s;
    logic             qbit_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic [WIDTH-1:0] rem_fix_s;
    logic [WIDTH-1:0] quo_fix_s;

    div_abs_cmp #(
        .WIDTH (WIDTH)
    ) u_abs_cmp (
        .signed_div (signed_div_i),
        .op_a       (opdata1_i),
        .op_b       (opdata2_i),
        .mag_a      (mag_a_s),
        .mag_b      (mag_b_s),
        .neg_a      (neg_a_s),
        .neg_b      (neg_b_s),
        .a_lt_b     (a_lt_b_s),
        .b_zero     (b_zero_s)
    );

    // One restoring step: shift in the next dividend bit, trial-subtract in
    // WIDTH+1 bits; the top bit of the difference is the borrow.
    always_comb begin
        rem_shift_s = {rem_r, dvd_r[WIDTH-1]};
        diff_s      = rem_shift_s - {1'b0, dsr_r};
        qbit_s      = ~diff_s[WIDTH];
        rem_next_s  = rem_shift_s[WIDTH-1:0];
        if (qbit_s) begin
            rem_next_s = diff_s[WIDTH-1:0];
        end else begin
            rem_next_s = rem_shift_s[WIDTH-1:0];
        end
        quo_next_s = {dvd_r[WIDTH-2:0], qbit_s};
    end

    // Sign fix-up of the final step. Most-negative / -1 needs no special case:
    // the magnitude quotient 2^(WIDTH-1) is already the wrapped value.
    always_comb begin
        quo_fix_s = quo_next_s;
        rem_fix_s = rem_next_s;
        if (neg_quo_r) begin
            quo_fix_s = ~quo_next_s + WIDTH'(1);
        end else begin
            quo_fix_s = quo_next_s;
        end
        if (neg_rem_r) begin
            rem_fix_s = ~rem_next_s + WIDTH'(1);
        end else begin
            rem_fix_s = rem_next_s;
        end
    end

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= DivIdle;
            cnt_r     <= {CNT_W{1'b0}};
            dvd_r     <= {WIDTH{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            dsr_r     <= {WIDTH{1'b0}};
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
            result_o  <= {(2*WIDTH){1'b0}};
            ready_o   <= 1'b0;
            busy_o    <= 1'b0;
            divzero_o <= 1'b0;
        end else if (annul_i) begin
            state_r   <= DivIdle;
            ready_o   <= 1'b0;
            busy_o    <= 1'b0;
            divzero_o <= 1'b0;
        end else begin
            case (state_r)
                DivIdle: begin
                    if (start_i == DivStart) begin
                        if (b_zero_s) begin
                            state_r   <= DivDone;
                            result_o  <= {(2*WIDTH){1'b0}};
                            divzero_o <= 1'b1;
                            ready_o   <= 1'b1;
                            busy_o    <= 1'b0;
                        end else if (EARLY_OUT && a_lt_b_s) begin
                            state_r   <= DivDone;
                            result_o  <= {opdata1_i, {WIDTH{1'b0}}};
                            divzero_o <= 1'b0;
                            ready_o   <= 1'b1;
                            busy_o    <= 1'b0;
                        end else begin
                            state_r   <= DivBusy;
                            cnt_r     <= {CNT_W{1'b0}};
                            dvd_r     <= mag_a_s;
                            rem_r     <= {WIDTH{1'b0}};
                            dsr_r     <= mag_b_s;
                            neg_quo_r <= neg_a_s ^ neg_b_s;
                            neg_rem_r <= neg_a_s;
                            divzero_o <= 1'b0;
                            ready_o   <= 1'b0;
                            busy_o    <= 1'b1;
                        end
                    end else begin
                        state_r <= DivIdle;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                end
                DivBusy: begin
                    rem_r <= rem_next_s;
                    dvd_r <= quo_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_r  <= DivDone;
                        result_o <= {rem_fix_s, quo_fix_s};
                        ready_o  <= 1'b1;
                        busy_o   <= 1'b0;
                    end else begin
                        state_r <= DivBusy;
                        busy_o  <= 1'b1;
                    end
                end
                DivDone: begin
                    if (start_i == DivStop) begin
                        state_r   <= DivIdle;
                        ready_o   <= 1'b0;
                        divzero_o <= 1'b0;
                    end else begin
                        state_r <= DivDone;
                        ready_o <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= DivIdle;
                    ready_o   <= 1'b0;
                    busy_o    <= 1'b0;
                    divzero_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: two 32-bit instances (early-out on/off)
// driven in lock-step and one 8-bit instance, checked against an arithmetic
// reference model.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        sgn32 = 1'b0, start32 = 1'b0, annul32 = 1'b0;
    logic [31:0] a32 = 32'd0, b32 = 32'd0;
    logic [63:0] res_e, res_n;
    logic        rdy_e, busy_e, dz_e, rdy_n, busy_n, dz_n;

    logic        sgn8 = 1'b0, start8 = 1'b0, annul8 = 1'b0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0;
    logic [15:0] res8;
    logic        rdy8, busy8, dz8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32), .EARLY_OUT(1'b1)) u_div_e (
        .clk(clk), .rst(rst), .signed_div_i(sgn32), .opdata1_i(a32), .opdata2_i(b32),
        .start_i(start32), .annul_i(annul32), .result_o(res_e), .ready_o(rdy_e),
        .busy_o(busy_e), .divzero_o(dz_e));

    div_iter #(.WIDTH(32), .EARLY_OUT(1'b0)) u_div_n (
        .clk(clk), .rst(rst), .signed_div_i(sgn32), .opdata1_i(a32), .opdata2_i(b32),
        .start_i(start32), .annul_i(annul32), .result_o(res_n), .ready_o(rdy_n),
        .busy_o(busy_n), .divzero_o(dz_n));

    div_iter #(.WIDTH(8), .EARLY_OUT(1'b1)) u_div_8 (
        .clk(clk), .rst(rst), .signed_div_i(sgn8), .opdata1_i(a8), .opdata2_i(b8),
        .start_i(start8), .annul_i(annul8), .result_o(res8), .ready_o(rdy8),
        .busy_o(busy8), .divzero_o(dz8));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division on sign-extended operands. lat is the
    // number of edges from the first edge seeing start until ready is seen.
    function automatic void ref_div(input int w, input bit s, input logic [63:0] a,
                                    input logic [63:0] b, input bit eo,
                                    output logic [127:0] res, output bit dz, output int lat);
        logic [63:0] mask;
        longint sa, sb, ma, mb, q, r;
        mask = (64'd1 << w) - 64'd1;
        sa = (s && a[w-1]) ? longint'(a | ~mask) : longint'(a & mask);
        sb = (s && b[w-1]) ? longint'(b | ~mask) : longint'(b & mask);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        dz = 1'b0;
        if (sb == 0) begin
            q = 0; r = 0; dz = 1'b1; lat = 1;
        end else if (eo && ma < mb) begin
            q = 0; r = sa; lat = 1;
        end else begin
            q = sa / sb; r = sa % sb; lat = w + 1;
        end
        res = (128'(64'(r) & mask) << w) | 128'(64'(q) & mask);
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'($urandom_range(0, 20));
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // One operation on both 32-bit instances, start held until both are ready,
    // then start dropped for one cycle.
    task automatic run32(input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [127:0] exp_e, exp_n;
        bit dzx_e, dzx_n;
        int lat_e, lat_n;
        int got_e = 0, got_n = 0;
        ref_div(32, s, 64'(a), 64'(b), 1'b1, exp_e, dzx_e, lat_e);
        ref_div(32, s, 64'(a), 64'(b), 1'b0, exp_n, dzx_n, lat_n);
        sgn32 = s; a32 = a; b32 = b; start32 = 1'b1;
        for (int k = 1; k <= 40 && (got_e == 0 || got_n == 0); k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                check("busy32e", 128'(busy_e), 128'(lat_e > 1));
                check("busy32n", 128'(busy_n), 128'(lat_n > 1));
                a32 = $urandom; b32 = $urandom; sgn32 = 1'($urandom_range(0, 1));
            end
            if (rdy_e && got_e == 0) got_e = k;
            if (rdy_n && got_n == 0) got_n = k;
        end
        check("lat32e", 128'(got_e), 128'(lat_e));
        check("lat32n", 128'(got_n), 128'(lat_n));
        check("res32e", 128'(res_e), exp_e);
        check("res32n", 128'(res_n), exp_n);
        check("dz32e", 128'(dz_e), 128'(dzx_e));
        check("dz32n", 128'(dz_n), 128'(dzx_n));
        start32 = 1'b0;
        @(posedge clk); #1;
        check("drop32_rdy", 128'({rdy_e, rdy_n, dz_e, dz_n}), 128'd0);
        check("hold32e", 128'(res_e), exp_e);
    endtask

    task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b);
        logic [127:0] expv;
        bit dzx;
        int lat;
        int got = 0;
        ref_div(8, s, 64'(a), 64'(b), 1'b1, expv, dzx, lat);
        sgn8 = s; a8 = a; b8 = b; start8 = 1'b1;
        for (int k = 1; k <= 14 && got == 0; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
            if (rdy8) got = k;
        end
        check("lat8", 128'(got), 128'(lat));
        check("res8", 128'(res8), expv);
        check("dz8", 128'(dz8), 128'(dzx));
        start8 = 1'b0;
        @(posedge clk); #1;
        check("drop8_rdy", 128'({rdy8, dz8}), 128'd0);
    endtask

    initial begin
        bit seen;
        #12;
        check("rst_e", 128'({res_e, rdy_e, busy_e, dz_e}), 128'd0);
        check("rst_n", 128'({res_n, rdy_n, busy_n, dz_n}), 128'd0);
        check("rst_8", 128'({res8, rdy8, busy8, dz8}), 128'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run32(1'b1, 32'hFFFF_FFF9, 32'd2);
        check("kat_m7_2", 128'(res_e), 128'({32'hFFFF_FFFF, 32'hFFFF_FFFD}));
        run32(1'b0, 32'hFFFF_FFFF, 32'h10);
        check("kat_udiv", 128'(res_e), 128'({32'h0000_000F, 32'h0FFF_FFFF}));
        run32(1'b0, 32'd1234, 32'd0);
        run32(1'b1, 32'hFFFF_FFFB, 32'd9);
        check("kat_early", 128'(res_n), 128'({32'hFFFF_FFFB, 32'h0}));
        run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("kat_mn", 128'(res_e), 128'({32'h0, 32'h8000_0000}));

        // Annul during BUSY cycle 10, with start still high
        sgn32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
        repeat (11) @(posedge clk);
        #1 annul32 = 1'b1;
        @(posedge clk); #1;
        check("annul_idle", 128'({busy_e, rdy_e, busy_n, rdy_n}), 128'd0);
        @(posedge clk); #1;
        check("annul_noacc", 128'({busy_e, busy_n, rdy_e, rdy_n}), 128'd0);
        annul32 = 1'b0; start32 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (rdy_e || rdy_n) seen = 1'b1;
        end
        check("annul_noready", 128'(seen), 128'd0);
        run32(1'b0, 32'd100, 32'd7);
        check("kat_100_7", 128'(res_e), 128'({32'd2, 32'd14}));

        // Asynchronous reset during BUSY cycle 5
        sgn32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_busy", 128'(busy_e), 128'd1);
        rst = 1'b0;
        #1;
        check("async_rst", 128'({res_e, rdy_e, busy_e, dz_e, res_n, rdy_n, busy_n, dz_n}), 128'd0);
        start32 = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            run32(1'($urandom_range(0, 1)), pick32(), pick32());
        end

        run8(1'b0, 8'd200, 8'd3);
        check("kat8_200_3", 128'(res8), 128'({8'd2, 8'd66}));
        run8(1'b1, 8'h80, 8'hFF);
        check("kat8_mn", 128'(res8), 128'({8'h00, 8'h80}));
        for (int i = 0; i < 40; i++) begin
            run8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
